// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and widths for the I2C/SCCB write-bus arbiter.
package i2c_arb_pkg;
  localparam int NUM_REQ_DEF = 3;
  localparam int CHIP_W      = 7;
  localparam int REG_W       = 8;
  localparam int DATA_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANTED,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [CHIP_W-1:0] chip;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } cmd_t;
endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side command bus plus the link to the shared write master.
interface i2c_bus_arbiter_if
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        cmd_valid;
  logic [NUM_REQ-1:0]        cmd_ready;
  logic [CHIP_W*NUM_REQ-1:0] cmd_chip;
  logic [REG_W*NUM_REQ-1:0]  cmd_reg;
  logic [DATA_W*NUM_REQ-1:0] cmd_data;
  logic [NUM_REQ-1:0]        cmd_done;
  logic [NUM_REQ-1:0]        cmd_err;
  logic                      m_start;
  logic [CHIP_W-1:0]         m_chip;
  logic [REG_W-1:0]          m_reg;
  logic [DATA_W-1:0]         m_data;
  logic                      m_done;
  logic                      m_ack_err;

  modport master (
    input  req, cmd_valid, cmd_chip, cmd_reg, cmd_data, m_done, m_ack_err,
    output gnt, cmd_ready, cmd_done, cmd_err, m_start, m_chip, m_reg, m_data
  );

  modport slave (
    output req, cmd_valid, cmd_chip, cmd_reg, cmd_data, m_done, m_ack_err,
    input  gnt, cmd_ready, cmd_done, cmd_err, m_start, m_chip, m_reg, m_data
  );
endinterface

// File: rtl/i2c_bus_arbiter_rr.sv
// Round-robin pick: search starts one past the last granted index.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] j;

  // Walk from lowest to highest priority so the highest-priority hit lands last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = N; k >= 1; k--) begin
      j = PW'((int'(last) + k) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C/SCCB write master among NUM_REQ init engines, one write at a time.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int          NUM_REQ = NUM_REQ_DEF,
  parameter logic [23:0] TIMEOUT = 24'd12600000
) (
  input logic               clk,
  input logic               reset,
  i2c_bus_arbiter_if.master bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, win;
  logic [PW-1:0]      ptr_q, ptr_d, win_idx;
  cmd_t               cmd_q, cmd_d;
  cmd_t [NUM_REQ-1:0] cmds;
  logic [23:0]        cnt_q, cnt_d;
  logic               err_q, err_d;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign cmds[gi] = '{chip: bus.cmd_chip[gi*CHIP_W +: CHIP_W],
                        addr: bus.cmd_reg[gi*REG_W +: REG_W],
                        data: bus.cmd_data[gi*DATA_W +: DATA_W]};
  end

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req  (bus.req),
    .last (ptr_q),
    .gnt  (win),
    .idx  (win_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      cmd_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ptr_q doubles as the current owner's index while a grant is held.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (|bus.req) begin
        gnt_d   = win;
        ptr_d   = win_idx;
        state_d = S_GRANTED;
      end
      S_GRANTED: begin
        if (bus.cmd_valid[ptr_q]) begin
          cmd_d   = cmds[ptr_q];
          state_d = S_ISSUE;
        end else if (!bus.req[ptr_q]) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.m_done) begin
          err_d   = bus.m_ack_err;
          state_d = S_DONE;
        end else if (cnt_q >= TIMEOUT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_DONE: begin
        if (bus.req[ptr_q]) begin
          state_d = S_GRANTED;
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.cmd_ready = (state_q == S_GRANTED) ? gnt_q : '0;
  assign bus.cmd_done  = (state_q == S_DONE) ? gnt_q : '0;
  assign bus.cmd_err   = (state_q == S_DONE && err_q) ? gnt_q : '0;
  assign bus.m_start   = (state_q == S_ISSUE);
  assign bus.m_chip    = cmd_q.chip;
  assign bus.m_reg     = cmd_q.addr;
  assign bus.m_data    = cmd_q.data;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed plus randomized bench; grant order predicted from round-robin rules.
module tb_i2c_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   chk_on = 1'b0;
  int   last = 2;

  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NUM_REQ(3)) bus ();

  i2c_bus_arbiter #(.NUM_REQ(3), .TIMEOUT(24'd100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (chk_on) chk("gnt_onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);

  // Next owner: first pending requester at or after last+1, wrapping.
  function automatic int pick(input logic [2:0] p, input int l);
    for (int k = 1; k <= 3; k++) if (p[(l + k) % 3]) return (l + k) % 3;
    return 0;
  endfunction

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 8 && !ok; t++) begin
      @(negedge clk);
      if (bus.gnt !== 3'b000) ok = 1'b1;
    end
    chk("gnt_arrive", {31'd0, ok}, 32'd1);
  endtask

  // Starts at a negedge with requester i holding the grant.
  task automatic do_write(input int i, input logic [6:0] c, input logic [7:0] r,
                          input logic [7:0] d, input int dly, input logic nack,
                          input logic drop, input logic tmo);
    int j, early;
    early = 0;
    j = (i + 1 + int'($urandom_range(0, 1))) % 3;
    chk("ready", bus.cmd_ready, 32'(1 << i));
    bus.cmd_valid = '0;
    bus.cmd_valid[i] = 1'b1;
    bus.cmd_valid[j] = 1'b1;
    bus.cmd_chip[i*7 +: 7] = c;
    bus.cmd_reg[i*8 +: 8]  = r;
    bus.cmd_data[i*8 +: 8] = d;
    bus.cmd_chip[j*7 +: 7] = ~c;
    bus.cmd_reg[j*8 +: 8]  = ~r;
    bus.cmd_data[j*8 +: 8] = ~d;
    @(negedge clk);
    bus.cmd_valid = '0;
    chk("m_start", {31'd0, bus.m_start}, 32'd1);
    chk("m_chip", bus.m_chip, c);
    chk("m_reg", bus.m_reg, r);
    chk("m_data", bus.m_data, d);
    @(negedge clk);
    chk("m_start_1cyc", {31'd0, bus.m_start}, 32'd0);
    if (drop) bus.req[i] = 1'b0;
    if (bus.cmd_done !== 3'b000) early++;
    if (tmo) begin
      repeat (100) begin
        @(negedge clk);
        if (bus.cmd_done !== 3'b000) early++;
      end
    end else begin
      repeat (dly) begin
        @(negedge clk);
        if (bus.cmd_done !== 3'b000) early++;
      end
      bus.m_done = 1'b1;
      bus.m_ack_err = nack;
    end
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.m_ack_err = 1'b0;
    chk("done_early", early, 0);
    chk("cmd_done", bus.cmd_done, 32'(1 << i));
    chk("cmd_err", bus.cmd_err, (tmo || nack) ? 32'(1 << i) : 32'd0);
    chk("m_chip_held", bus.m_chip, c);
    @(negedge clk);
    chk("done_pulse", bus.cmd_done, 32'd0);
    chk("gnt_after", bus.gnt, drop ? 32'd0 : 32'(1 << i));
  endtask

  // Serve every requester in pat until each has dropped its request.
  task automatic serve(input logic [2:0] pat, input bit rnd);
    logic [2:0] pend;
    logic       ok;
    int         e, nw;
    pend = pat;
    bus.req = pat;
    while (pend != 3'b000) begin
      wait_gnt(ok);
      e = pick(pend, last);
      chk("rr_gnt", bus.gnt, 32'(1 << e));
      nw = rnd ? int'($urandom_range(1, 3)) : 1;
      for (int w = 0; w < nw; w++) begin
        if (rnd)
          do_write(e, 7'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), w == nw - 1, 1'b0);
        else
          do_write(e, 7'(7'h20 + e), 8'(8'h30 + e), 8'(8'h50 + e), 1, e == 1, 1'b1, 1'b0);
      end
      last = e;
      pend[e] = 1'b0;
    end
  endtask

  initial begin
    logic ok;
    bus.req = '0; bus.cmd_valid = '0; bus.cmd_chip = '0; bus.cmd_reg = '0;
    bus.cmd_data = '0; bus.m_done = 1'b0; bus.m_ack_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_done", bus.cmd_done, 0);
    chk("rst_mstart", {31'd0, bus.m_start}, 0);
    chk("rst_mfields", {9'd0, bus.m_chip, bus.m_reg, bus.m_data}, 0);
    reset = 1'b1;

    // Contention from reset: order 0,1,2; requester 1 gets a NACK.
    serve(3'b111, 1'b0);

    // Single request with the reference write.
    bus.req = 3'b001;
    wait_gnt(ok);
    chk("single_gnt", bus.gnt, 3'b001);
    do_write(0, 7'h39, 8'h41, 8'h10, 2, 1'b0, 1'b1, 1'b0);
    last = 0;

    // Timeout, then a stray m_done outside the wait phase.
    bus.req = 3'b010;
    wait_gnt(ok);
    chk("tmo_gnt", bus.gnt, 3'b010);
    do_write(1, 7'h12, 8'h34, 8'h56, 0, 1'b0, 1'b1, 1'b1);
    last = 1;
    bus.m_done = 1'b1;
    bus.m_ack_err = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.m_ack_err = 1'b0;
    chk("late_done", bus.cmd_done, 0);
    chk("late_gnt", bus.gnt, 0);
    @(negedge clk);
    chk("late_done2", bus.cmd_done, 0);

    // Reset while waiting on the master.
    bus.req = 3'b010;
    wait_gnt(ok);
    chk("rstw_gnt", bus.gnt, 3'b010);
    bus.cmd_valid[1] = 1'b1;
    bus.cmd_chip[13:7] = 7'h55;
    @(negedge clk);
    bus.cmd_valid = '0;
    @(negedge clk);
    bus.req = 3'b111;
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_gnt0", bus.gnt, 0);
    chk("rstw_ready", bus.cmd_ready, 0);
    chk("rstw_done", bus.cmd_done, 0);
    chk("rstw_err", bus.cmd_err, 0);
    chk("rstw_mstart", {31'd0, bus.m_start}, 0);
    chk("rstw_mchip", bus.m_chip, 0);
    reset = 1'b1;
    last = 2;
    serve(3'b111, 1'b0);

    // Randomized contention with multi-write bursts and random NACKs.
    for (int rnd_i = 0; rnd_i < 8; rnd_i++)
      serve(3'($urandom_range(1, 7)), 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
